// File: rtl/psw_conditioner_pkg.sv
// rtl/psw_conditioner_pkg.sv - shared push-button timing and index constants
package psw_conditioner_pkg;

  // Timing at the 1 kHz board clock
  localparam int DEBOUNCE_CYC_1K = 20;
  localparam int LONG_CYC_1K     = 1000;

  // Button roles, shared with the stopwatch control logic
  localparam int PSW_START = 3;
  localparam int PSW_STOP  = 2;
  localparam int PSW_CLEAR = 1;
  localparam int PSW_SPARE = 0;

endpackage

// File: rtl/psw_debounce_ch.sv
// rtl/psw_debounce_ch.sv - one button channel: sync, debounce, press and long-press pulses
module psw_debounce_ch
  import psw_conditioner_pkg::*;
#(
  parameter bit ACTIVE_LOW   = 1'b0,
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_1K,
  parameter int LONG_CYC     = LONG_CYC_1K,
  parameter int DB_W         = 5,
  parameter int LONG_W       = 10
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic pulse_o,
  output logic long_o
);

  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              stable_q, stable_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [LONG_W-1:0] hold_q, hold_d;
  logic              pulse_q, pulse_d;
  logic              long_q, long_d;
  logic              accept;

  // Next-state: polarity fix into the synchroniser, debounce count, hold count
  always_comb begin
    sync1_d  = raw_i ^ ACTIVE_LOW;
    sync2_d  = sync1_q;
    accept   = (sync2_q != stable_q) && (db_cnt_q == DB_W'(DEBOUNCE_CYC - 1));
    stable_d = stable_q;
    db_cnt_d = '0;
    if (accept) begin
      stable_d = sync2_q;
    end else if (sync2_q != stable_q) begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end
    // Press pulse only on an accepted rising change of the stable level
    pulse_d = accept & sync2_q;
    hold_d  = '0;
    if (stable_q) begin
      hold_d = (hold_q == LONG_W'(LONG_CYC)) ? hold_q : hold_q + LONG_W'(1);
    end
    // Fires on the single edge where the saturating hold count reaches LONG_CYC
    long_d = stable_q && (hold_q == LONG_W'(LONG_CYC - 1));
  end

  // State register with synchronous active-high reset discarding all progress
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      db_cnt_q <= '0;
      hold_q   <= '0;
      pulse_q  <= 1'b0;
      long_q   <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      db_cnt_q <= db_cnt_d;
      hold_q   <= hold_d;
      pulse_q  <= pulse_d;
      long_q   <= long_d;
    end
  end

  assign level_o = stable_q;
  assign pulse_o = pulse_q;
  assign long_o  = long_q;

endmodule

// File: rtl/psw_conditioner.sv
// rtl/psw_conditioner.sv - N_BTN independent push-button conditioning channels
module psw_conditioner
  import psw_conditioner_pkg::*;
#(
  parameter int N_BTN        = 4,
  parameter bit ACTIVE_LOW   = 1'b0,
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_1K,
  parameter int LONG_CYC     = LONG_CYC_1K,
  parameter int DB_W         = 5,
  parameter int LONG_W       = 10
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_BTN-1:0] PSW_RAW,
  output logic [N_BTN-1:0] PSW_LEVEL,
  output logic [N_BTN-1:0] PSW_PULSE,
  output logic [N_BTN-1:0] PSW_LONG
);

  // Channels share nothing but clock and reset; no priority between buttons
  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    psw_debounce_ch #(
      .ACTIVE_LOW  (ACTIVE_LOW),
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .LONG_CYC    (LONG_CYC),
      .DB_W        (DB_W),
      .LONG_W      (LONG_W)
    ) u_ch (
      .clk_i  (CLK),
      .rst_i  (RST),
      .raw_i  (PSW_RAW[g]),
      .level_o(PSW_LEVEL[g]),
      .pulse_o(PSW_PULSE[g]),
      .long_o (PSW_LONG[g])
    );
  end

endmodule

// File: tb/tb_psw_conditioner.sv
// tb/tb_psw_conditioner.sv - scoreboard bench for psw_conditioner
module tb_psw_conditioner;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic [3:0]      raw0 = 4'b0000;
  logic [3:0]      raw1 = 4'b1111;
  logic [1:0][3:0] lvl, pls, lng;
  logic [1:0][3:0] prev_lvl;

  int cyc     = 0;
  int n_total = 0;
  int n_pass  = 0;
  bit mon_en  = 1'b0;

  typedef struct {
    int       inst;
    int       cyc;
    logic [3:0] level;
    logic [3:0] pulse;
    logic [3:0] lng;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  psw_conditioner #(
    .N_BTN(4), .ACTIVE_LOW(1'b0), .DEBOUNCE_CYC(4), .LONG_CYC(10), .DB_W(5), .LONG_W(10)
  ) u_dut_hi (
    .CLK(CLK), .RST(RST), .PSW_RAW(raw0),
    .PSW_LEVEL(lvl[0]), .PSW_PULSE(pls[0]), .PSW_LONG(lng[0])
  );

  psw_conditioner #(
    .N_BTN(4), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYC(4), .LONG_CYC(10), .DB_W(5), .LONG_W(10)
  ) u_dut_lo (
    .CLK(CLK), .RST(RST), .PSW_RAW(raw1),
    .PSW_LEVEL(lvl[1]), .PSW_PULSE(pls[1]), .PSW_LONG(lng[1])
  );

  // Monitor: any pulse, long pulse or level change is an event to match against the queue
  always @(negedge CLK) begin
    if (mon_en) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        n_total++;
        $display("FAIL missed_event inst=%0d cyc=%0d actual=none required level=%b pulse=%b long=%b",
                 exp_q[0].inst, exp_q[0].cyc, exp_q[0].level, exp_q[0].pulse, exp_q[0].lng);
        void'(exp_q.pop_front());
      end
      for (int i = 0; i < 2; i++) begin
        if (pls[i] !== 4'b0 || lng[i] !== 4'b0 || lvl[i] !== prev_lvl[i]) begin
          n_total++;
          if (exp_q.size() == 0) begin
            $display("FAIL unexpected_event inst=%0d cyc=%0d actual level=%b pulse=%b long=%b required=none",
                     i, cyc, lvl[i], pls[i], lng[i]);
          end else begin
            mon_e = exp_q.pop_front();
            if (mon_e.inst == i && mon_e.cyc == cyc && lvl[i] === mon_e.level &&
                pls[i] === mon_e.pulse && lng[i] === mon_e.lng) begin
              n_pass++;
            end else begin
              $display("FAIL event inst=%0d cyc=%0d actual level=%b pulse=%b long=%b required inst=%0d cyc=%0d level=%b pulse=%b long=%b",
                       i, cyc, lvl[i], pls[i], lng[i], mon_e.inst, mon_e.cyc, mon_e.level, mon_e.pulse, mon_e.lng);
            end
          end
        end
        prev_lvl[i] = lvl[i];
      end
    end else begin
      prev_lvl = lvl;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic push(input int inst, input int c, input logic [3:0] lv,
                      input logic [3:0] pl, input logic [3:0] lg);
    ev_t e;
    e.inst = inst; e.cyc = c; e.level = lv; e.pulse = pl; e.lng = lg;
    exp_q.push_back(e);
  endtask

  task automatic check_zero(input string name, input logic [3:0] act);
    n_total++;
    if (act === 4'b0000) n_pass++;
    else $display("FAIL %s actual=%b required=0000", name, act);
  endtask

  int n;
  int hi_t[8] = '{1, 3, 2, 3, 1, 2, 3, 1};
  int lo_t[8] = '{1, 2, 1, 1, 2, 2, 3, 2};

  initial begin
    // Reset for two edges, then idle outputs must be zero on both polarities
    wait_cyc(2);
    RST = 1'b0;
    wait_cyc(1);
    check_zero("reset_level_hi", lvl[0]);
    check_zero("reset_pulse_hi", pls[0]);
    check_zero("reset_long_hi",  lng[0]);
    check_zero("reset_level_lo", lvl[1]);
    check_zero("reset_pulse_lo", pls[1]);
    check_zero("reset_long_lo",  lng[1]);
    mon_en = 1'b1;
    wait_cyc(50);

    // Clean press on bit 3: pulse 6 edges after driving, long 10 edges later
    n = cyc; raw0[3] = 1'b1;
    push(0, n + 6,  4'b1000, 4'b1000, 4'b0000);
    push(0, n + 16, 4'b1000, 4'b0000, 4'b1000);
    wait_cyc(25);
    n = cyc; raw0[3] = 1'b0;
    push(0, n + 6, 4'b0000, 4'b0000, 4'b0000);
    wait_cyc(15);

    // Bounce on bit 2 with high phases of at most 3 cycles: nothing accepted
    for (int k = 0; k < 8; k++) begin
      raw0[2] = 1'b1; wait_cyc(hi_t[k]);
      raw0[2] = 1'b0; wait_cyc(lo_t[k]);
    end
    wait_cyc(20);

    // Long press on bit 1, then a short hold that must not fire long
    n = cyc; raw0[1] = 1'b1;
    push(0, n + 6,  4'b0010, 4'b0010, 4'b0000);
    push(0, n + 16, 4'b0010, 4'b0000, 4'b0010);
    wait_cyc(20);
    n = cyc; raw0[1] = 1'b0;
    push(0, n + 6, 4'b0000, 4'b0000, 4'b0000);
    wait_cyc(20);
    n = cyc; raw0[1] = 1'b1;
    push(0, n + 6,  4'b0010, 4'b0010, 4'b0000);
    wait_cyc(8);
    raw0[1] = 1'b0;
    push(0, n + 14, 4'b0000, 4'b0000, 4'b0000);
    wait_cyc(30);

    // Active-low instance: simultaneous presses on bits 3 and 0
    n = cyc; raw1 = 4'b0110;
    push(1, n + 6,  4'b1001, 4'b1001, 4'b0000);
    push(1, n + 16, 4'b1001, 4'b0000, 4'b1001);
    wait_cyc(20);
    n = cyc; raw1 = 4'b1111;
    push(1, n + 6, 4'b0000, 4'b0000, 4'b0000);
    wait_cyc(20);

    // Reset at debounce count 2, then again mid-hold; press must re-debounce fully
    n = cyc; raw0[0] = 1'b1;
    wait_cyc(4);
    RST = 1'b1;
    wait_cyc(1);
    RST = 1'b0;
    push(0, n + 11, 4'b0001, 4'b0001, 4'b0000);
    wait_cyc(10);
    RST = 1'b1;
    push(0, n + 16, 4'b0000, 4'b0000, 4'b0000);
    wait_cyc(1);
    RST = 1'b0;
    push(0, n + 22, 4'b0001, 4'b0001, 4'b0000);
    push(0, n + 32, 4'b0001, 4'b0000, 4'b0001);
    wait_cyc(19);
    raw0[0] = 1'b0;
    push(0, n + 41, 4'b0000, 4'b0000, 4'b0000);
    wait_cyc(20);

    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL queue_drained actual=%0d pending required=0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
